bitscan_seq: RTL and testbench
==============================

# bitscan_seq

Sequential bit-list scanner for the datapath: the inverse of the bitwise OR/merge cells. It accepts an N-bit mask in one cycle and returns it as a stream of one-hot words, lowest set bit first, one per accepted handshake, each with its binary index. It serves the LDM/STM register-list walk and any other control path that must decompose a merged bit vector into individual selects. OR-ing every Y word emitted for one load reproduces the loaded mask exactly.

## Interface
- N, 16, mask width (N ≥ 2)
- W, 4, index width; N ≤ 2**W
- DPFLAG, 1, datapath placement flag, passed through to layout tools, no functional effect
- GROUP, "dpath1", datapath group name, no functional effect

- CLK  input  1  single clock; all state changes on rising edge
- RST  input  1  reset, synchronous, active-high
- LOAD  input  1  load request; honoured only when READY=1
- IN  input  N  mask to scan; sampled on the edge where LOAD & READY
- READY  output  1  block idle, can take LOAD
- VALID  output  1  Y/IDX/LAST hold a valid element
- Y  output  N  one-hot lowest remaining set bit; 0 when VALID=0
- IDX  output  W  binary index of Y's set bit; 0 when VALID=0
- LAST  output  1  current element is the final one of this mask
- ACK  input  1  consumer takes the current element; honoured only when VALID=1
- DONE  output  1  one-cycle pulse: scan of the loaded mask finished

## Operation
- State: 2-state FSM, IDLE/SCAN, plus N-bit remaining-mask register MASK and registered DONE flag.
- Reset (RST=1 at an edge): state=IDLE, MASK=0, DONE=0. Resulting outputs: READY=1, VALID=0, Y=0, IDX=0, LAST=0, DONE=0. RST overrides LOAD and ACK in the same cycle.
- IDLE: READY=1, VALID=0. On LOAD:
  - IN≠0: MASK←IN, state→SCAN.
  - IN=0: MASK stays 0, state stays IDLE, DONE←1 for one cycle.
- SCAN: READY=0, VALID=1.
  - Y = MASK & (~MASK + 1), the lowest set bit of MASK.
  - IDX = position of that bit.
  - LAST = 1 iff MASK has exactly one bit set.
  - On ACK: MASK←MASK & ~Y. If LAST: state→IDLE, DONE←1.
- LOAD while READY=0 is ignored, with no effect on MASK. ACK while VALID=0 is ignored.
- DONE is cleared on every edge where it is not being set, so it is always a single-cycle pulse.
- Y, IDX, LAST and READY are combinational from the state and MASK registers. VALID equals (state==SCAN).
- Bit N-1 is a legal element: IDX=N-1, and no wrap or overflow past it.
- Reset during SCAN abandons the current mask with no DONE pulse.

## Timing
- Load-to-first-element latency: 1 cycle. LOAD sampled at edge k gives VALID=1 with the first element after edge k.
- Throughput: one element per cycle while ACK is held high.
- A mask with P set bits, ACK held high, occupies P cycles in SCAN. DONE=1 and READY=1 in the cycle after the final ACK edge.
- A new LOAD is accepted in the same cycle DONE is high, so back-to-back masks have one idle cycle between last element and next first element.
- Zero mask: DONE=1 in the cycle after the LOAD edge, VALID never asserts.

## Test plan
- Reset then idle: hold RST 2 cycles with LOAD=1, IN=16'hFFFF -> READY=1, VALID=0, Y=0, IDX=0, LAST=0, DONE=0. Nothing is loaded.
- Basic scan: LOAD IN=16'h8013, ACK=1 continuous -> elements in order:
  - Y=0001, IDX=0
  - Y=0002, IDX=1
  - Y=0010, IDX=4
  - Y=8000, IDX=15, LAST=1
  - then DONE pulse, READY=1.
  - OR of all Y words equals 16'h8013.
- Stall: LOAD IN=16'h0006, ACK=0 for 3 cycles -> Y=0002, IDX=1 held stable. ACK=1 -> Y=0004, IDX=2, LAST=1. Next ACK -> DONE.
- Zero and full masks:
  - LOAD IN=0 -> DONE=1 next cycle, VALID stays 0.
  - LOAD IN=16'hFFFF with ACK=1 -> 16 elements, IDX 0..15, LAST only on IDX=15.
- Ignored inputs: during SCAN of 16'h0300, pulse LOAD with IN=16'h0001 and pulse ACK while VALID=0 (before load) -> no effect. Scan still yields IDX 8, then IDX 9.
- Reset mid-scan: LOAD 16'h00F0, one ACK, then RST -> next cycle VALID=0, READY=1, DONE=0. A following LOAD of 16'h0001 yields IDX=0, LAST=1.

Source files
------------

// File: rtl/bitscan_seq_if.sv
// Handshake bundle for the bit-list scanner: mask load on one side, one-hot element stream on the other.
interface bitscan_seq_if #(
  parameter int N = 16,
  parameter int W = 4
);
  logic         LOAD;
  logic [N-1:0] IN;
  logic         READY;
  logic         VALID;
  logic [N-1:0] Y;
  logic [W-1:0] IDX;
  logic         LAST;
  logic         ACK;
  logic         DONE;

  modport slave  (input LOAD, IN, ACK, output READY, VALID, Y, IDX, LAST, DONE);
  modport master (output LOAD, IN, ACK, input READY, VALID, Y, IDX, LAST, DONE);
endinterface

// File: rtl/bitscan_seq.sv
// Sequential bit-list scanner: loads an N-bit mask and emits its set bits lowest-first as one-hot words.
module bitscan_seq #(
  parameter int N      = 16,
  parameter int W      = 4,
  parameter bit DPFLAG = 1'b1,
  parameter     GROUP  = "dpath1"
) (
  input  logic          CLK,
  input  logic          RST,
  bitscan_seq_if.slave  bus
);
  typedef enum logic {IDLE, SCAN} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] mask_q, mask_d;
  logic         done_q, done_d;

  logic         scan;
  logic [N-1:0] low;
  logic [W-1:0] low_idx;
  logic         single;

  // Layout-only parameters; folded here so they are referenced.
  logic unused_cfg;
  assign unused_cfg = ^{DPFLAG, GROUP};

  always_comb begin
    scan    = (state_q == SCAN);
    low     = mask_q & (~mask_q + N'(1));
    low_idx = '0;
    for (int i = 0; i < N; i++)
      if (low[i]) low_idx = W'(i);
    // Clearing the lowest bit leaves zero only when exactly one bit remains.
    single  = (mask_q != '0) && ((mask_q & (mask_q - N'(1))) == '0);
  end

  assign bus.READY = !scan;
  assign bus.VALID = scan;
  assign bus.Y     = scan ? low : '0;
  assign bus.IDX   = scan ? low_idx : '0;
  assign bus.LAST  = scan & single;
  assign bus.DONE  = done_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.LOAD) begin
        if (bus.IN != '0) begin
          mask_d  = bus.IN;
          state_d = SCAN;
        end else begin
          done_d  = 1'b1;
        end
      end
      SCAN: if (bus.ACK) begin
        mask_d = mask_q & ~low;
        if (single) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_bitscan_seq.sv
// Randomized scoreboard bench for bitscan_seq: stimulus pushes expected elements, a negedge monitor pops and checks.
module tb_bitscan_seq;
  localparam int N = 16;
  localparam int W = 4;

  typedef struct {
    logic [N-1:0] y;
    logic [W-1:0] idx;
    logic         last;
  } elem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bitscan_seq_if #(.N(N), .W(W)) bif ();
  bitscan_seq #(.N(N), .W(W)) dut (.CLK(clk), .RST(rst), .bus(bif));

  elem_t        exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  bit           mon_en   = 1'b0;
  logic         done_want = 1'b0;
  logic [N-1:0] or_acc   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every set bit of the mask, ascending, last flag on the highest one.
  task automatic push_mask(input logic [N-1:0] m);
    int hi = -1;
    elem_t e;
    for (int i = 0; i < N; i++) if (m[i]) hi = i;
    for (int i = 0; i < N; i++)
      if (m[i]) begin
        e.y    = '0;
        e.y[i] = 1'b1;
        e.idx  = W'(i);
        e.last = (i == hi);
        exp_q.push_back(e);
      end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic front_last;
      front_last = 1'b0;
      chk("done", bif.DONE, done_want);
      chk("ready", bif.READY, !bif.VALID);
      if (bif.VALID) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_element", bif.Y, 0);
        end else begin
          chk("y", bif.Y, exp_q[0].y);
          chk("idx", bif.IDX, exp_q[0].idx);
          chk("last", bif.LAST, exp_q[0].last);
          front_last = exp_q[0].last;
          if (bif.ACK && !rst) begin
            or_acc |= exp_q[0].y;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("idle_y", bif.Y, 0);
        chk("idle_idx", bif.IDX, 0);
        chk("idle_last", bif.LAST, 0);
      end
      done_want = !rst && ((bif.VALID && bif.ACK && front_last) ||
                           (bif.READY && bif.LOAD && bif.IN == '0));
    end
  end

  task automatic wait_ready();
    int cnt = 0;
    while (!bif.READY && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt >= 100) chk("ready_timeout", 1, 0);
  endtask

  task automatic do_load(input logic [N-1:0] m);
    wait_ready();
    bif.LOAD = 1'b1;
    bif.IN   = m;
    push_mask(m);
    @(posedge clk); #1;
    bif.LOAD = 1'b0;
  endtask

  // Drive ACK (always or randomly) until every expected element is consumed.
  task automatic drain(input bit rnd_ack);
    int cnt = 0;
    while (exp_q.size() > 0 && cnt < 300) begin
      bif.ACK = rnd_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
      cnt++;
    end
    bif.ACK = 1'b0;
    if (cnt >= 300) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] m;
    bif.LOAD = 1'b1;
    bif.IN   = 16'hFFFF;
    bif.ACK  = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", bif.READY, 1);
    chk("rst_valid", bif.VALID, 0);
    chk("rst_y", bif.Y, 0);
    chk("rst_idx", bif.IDX, 0);
    chk("rst_last", bif.LAST, 0);
    chk("rst_done", bif.DONE, 0);
    rst      = 1'b0;
    bif.LOAD = 1'b0;
    bif.IN   = '0;
    @(posedge clk); #1;

    // Basic scan with OR reconstruction
    or_acc = '0;
    do_load(16'h8013);
    drain(1'b0);
    @(posedge clk); #1;
    chk("or_of_y", or_acc, 16'h8013);

    // Stall: element must hold while ACK is low
    do_load(16'h0006);
    repeat (3) begin @(posedge clk); #1; end
    drain(1'b0);
    @(posedge clk); #1;

    // Zero mask, then full mask
    do_load(16'h0000);
    repeat (2) begin @(posedge clk); #1; end
    do_load(16'hFFFF);
    drain(1'b0);
    @(posedge clk); #1;

    // Ignored ACK while idle, ignored LOAD while scanning
    bif.ACK = 1'b1;
    @(posedge clk); #1;
    bif.ACK = 1'b0;
    do_load(16'h0300);
    bif.LOAD = 1'b1;
    bif.IN   = 16'h0001;
    @(posedge clk); #1;
    bif.LOAD = 1'b0;
    drain(1'b0);
    @(posedge clk); #1;

    // Reset mid-scan abandons the mask without DONE
    do_load(16'h00F0);
    bif.ACK = 1'b1;
    @(posedge clk); #1;
    bif.ACK = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_valid", bif.VALID, 0);
    chk("midrst_ready", bif.READY, 1);
    chk("midrst_done", bif.DONE, 0);
    do_load(16'h0001);
    drain(1'b0);
    @(posedge clk); #1;

    // Randomized masks, random ACK, frequent back-to-back loads
    for (int k = 0; k < 40; k++) begin
      m = N'($urandom_range(0, 65535));
      if ($urandom_range(0, 2) == 0) m &= N'($urandom_range(0, 65535));
      if ($urandom_range(0, 9) == 0) m = '0;
      if ($urandom_range(0, 9) == 0) m = 16'h8000;
      do_load(m);
      drain(1'b1);
      if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
